// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative AES InvMixColumns engine, one column per clock.
// Define INV_MIX_PARALLEL_EN to process all four columns in a single BUSY cycle.
module inv_mix_columns_seq #(
  parameter bit HOLD_OUTPUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t       state, state_d;
  logic [1:0]   col_cnt, col_cnt_d;
  logic [127:0] work, work_d;
  logic [127:0] out_data_d;
  logic         out_valid_d;
  logic [127:0] work_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Each output row r combines the column bytes rotated so a[r] gets the 0e weight.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m09[4];
    logic [7:0]  m0b[4];
    logic [7:0]  m0d[4];
    logic [7:0]  m0e[4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      x2 = xtime(a[i]);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m09[i] = x8 ^ a[i];
      m0b[i] = x8 ^ x2 ^ a[i];
      m0d[i] = x8 ^ x4 ^ a[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int i = 0; i < 4; i++)
      res[31-8*i -: 8] = m0e[i] ^ m0b[(i+1)%4] ^ m0d[(i+2)%4] ^ m09[(i+3)%4];
    return res;
  endfunction

  assign IN_READY = (state == ST_IDLE);
  assign BUSY     = (state == ST_BUSY);

`ifdef INV_MIX_PARALLEL_EN
  assign work_mixed = {inv_mix_col(work[127:96]), inv_mix_col(work[95:64]),
                       inv_mix_col(work[63:32]),  inv_mix_col(work[31:0])};
`else
  always_comb begin
    work_mixed = work;
    case (col_cnt)
      2'd0:    work_mixed[127:96] = inv_mix_col(work[127:96]);
      2'd1:    work_mixed[95:64]  = inv_mix_col(work[95:64]);
      2'd2:    work_mixed[63:32]  = inv_mix_col(work[63:32]);
      default: work_mixed[31:0]   = inv_mix_col(work[31:0]);
    endcase
  end
`endif

  always_comb begin
    state_d     = state;
    col_cnt_d   = col_cnt;
    work_d      = work;
    out_data_d  = OUT_DATA;
    out_valid_d = OUT_VALID;
    case (state)
      ST_IDLE: begin
        if (IN_VALID) begin
          work_d    = IN_DATA;
          col_cnt_d = 2'd0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d = work_mixed;
`ifdef INV_MIX_PARALLEL_EN
        col_cnt_d   = 2'd0;
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        out_data_d  = work_mixed;
`else
        col_cnt_d = col_cnt + 2'd1;
        if (col_cnt == 2'd3) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_mixed;
        end
`endif
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          if (!HOLD_OUTPUT) out_data_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_cnt   <= 2'd0;
      work      <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      state     <= state_d;
      col_cnt   <= col_cnt_d;
      work      <= work_d;
      OUT_DATA  <= out_data_d;
      OUT_VALID <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed and model-based checks for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_PARALLEL_EN
  localparam int LAT = 1;
  localparam int PER = 3;
`else
  localparam int LAT = 4;
  localparam int PER = 6;
`endif

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] RT_IN   = 128'h4d7ebdf8_c6c6c6c6_01010101_8e4da1bc;
  localparam logic [127:0] RT_OUT  = 128'h2d26314c_c6c6c6c6_01010101_db135345;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready, in_ready_h0;
  logic [127:0] in_data = '0;
  logic         out_valid, out_valid_h0;
  logic         out_ready = 1'b0;
  logic [127:0] out_data, out_data_h0;
  logic         busy, busy_h0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.HOLD_OUTPUT(1'b1)) dut (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .BUSY(busy)
  );

  inv_mix_columns_seq #(.HOLD_OUTPUT(1'b0)) dut_h0 (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready_h0), .IN_DATA(in_data),
    .OUT_VALID(out_valid_h0), .OUT_READY(out_ready), .OUT_DATA(out_data_h0), .BUSY(busy_h0)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   b [4];
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[127-32*c-8*k -: 8];
      for (int k = 0; k < 4; k++)
        r[127-32*c-8*k -: 8] = gmul(8'h0e, b[k]) ^ gmul(8'h0b, b[(k+1)%4]) ^
                               gmul(8'h0d, b[(k+2)%4]) ^ gmul(8'h09, b[(k+3)%4]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] d, output logic [127:0] res, output int lat);
    int n = 0;
    lat = -1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 128'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vector();
    logic [127:0] res;
    int lat;
    run_block(VEC_IN, res, lat);
    total++; if (res !== VEC_OUT) $display("FAIL vector_data got %h want %h", res, VEC_OUT); else passed++;
    total++; if (lat !== LAT) $display("FAIL vector_latency got %0d want %0d", lat, LAT); else passed++;
    run_block({4{32'hffffffff}}, res, lat);
    total++; if (res !== {4{32'hffffffff}}) $display("FAIL vector_ones got %h want all ff", res); else passed++;
    run_block(128'h0, res, lat);
    total++; if (res !== 128'h0) $display("FAIL vector_zero got %h want 0", res); else passed++;
  endtask

  task automatic test_round_trip();
    logic [127:0] res, d, exp;
    int lat;
    int errs = 0;
    run_block(RT_IN, res, lat);
    total++; if (res !== RT_OUT) $display("FAIL round_trip_fixed got %h want %h", res, RT_OUT); else passed++;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = model(d);
      run_block(d, res, lat);
      total++;
      if (res !== exp || lat !== LAT) begin
        errs++;
        if (errs <= 5) $display("FAIL random_%0d got %h lat %0d want %h lat %0d", i, res, lat, exp, LAT);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] first;
    int lat = -1;
    bit seen = 1'b0;
    in_valid = 1'b1;
    in_data  = VEC_IN;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    first = out_data;
    total++; if (lat !== LAT) $display("FAIL bp_latency got %0d want %0d", lat, LAT); else passed++;
    total++; if (first !== VEC_OUT) $display("FAIL bp_data got %h want %h", first, VEC_OUT); else passed++;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin in_valid = 1'b1; in_data = RT_IN; end
      if (k == 4) begin in_valid = 1'b0; in_data = 'x; end
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_%0d got %b want 1", k, out_valid); else passed++;
      total++; if (out_data !== VEC_OUT) $display("FAIL bp_hold_%0d got %h want %h", k, out_data, VEC_OUT); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d got %b want 0", k, in_ready); else passed++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else passed++;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL bp_ignored_input got activity 1 want 0"); else passed++;
  endtask

  task automatic test_hold_output();
    logic [127:0] res;
    int lat;
    run_block(RT_IN, res, lat);
    total++; if (out_data !== RT_OUT) $display("FAIL hold1_out_data got %h want %h", out_data, RT_OUT); else passed++;
    total++; if (out_data_h0 !== 128'h0) $display("FAIL hold0_out_data got %h want 0", out_data_h0); else passed++;
    total++; if (out_valid_h0 !== 1'b0) $display("FAIL hold0_out_valid got %b want 0", out_valid_h0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] ins [3];
    logic [127:0] got [3];
    int when [3];
    int idx = 0;
    int nout = 0;
    bit acc;
    ins[0] = VEC_IN;
    ins[1] = RT_IN;
    ins[2] = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_valid  = 1'b1;
    in_data   = ins[0];
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_data = ins[idx];
        else begin in_valid = 1'b0; in_data = 'x; end
      end
      if (out_valid === 1'b1 && nout < 3) begin
        got[nout]  = out_data;
        when[nout] = cyc;
        nout++;
      end
    end
    out_ready = 1'b0;
    total++; if (nout !== 3) $display("FAIL b2b_count got %0d want 3", nout); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got[k] !== model(ins[k])) $display("FAIL b2b_data_%0d got %h want %h", k, got[k], model(ins[k]));
      else passed++;
    end
    total++; if (when[1] - when[0] !== PER) $display("FAIL b2b_period got %0d want %0d", when[1] - when[0], PER); else passed++;
    total++; if (when[2] - when[1] !== PER) $display("FAIL b2b_period2 got %0d want %0d", when[2] - when[1], PER); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    in_valid = 1'b1;
    in_data  = RT_IN;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got %b want 0", in_ready); else passed++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 128'h0) $display("FAIL mid_rst_data got %h want 0", out_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else passed++;
    run_block(VEC_IN, res, lat);
    total++; if (res !== VEC_OUT) $display("FAIL mid_fresh_data got %h want %h", res, VEC_OUT); else passed++;
    total++; if (lat !== LAT) $display("FAIL mid_fresh_latency got %0d want %0d", lat, LAT); else passed++;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_backpressure();
    test_hold_output();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
